manchester_deframer: RTL

- Sits directly downstream of the Manchester decoder and consumes its recovered serial bit stream (d_decod) plus a one-cycle bit strobe.
- Hunts for a sync byte at any bit alignment, then reads a length byte and assembles payload bytes, MSB first.
- Presents each payload byte with a valid pulse, flags start/end of frame, and reports framing errors.
- Provides the byte-level receive path for the Manchester link.

---
 rtl/manchester_deframer.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/manchester_deframer.sv
// manchester_deframer: byte-level receive path behind the Manchester decoder.
// Hunts for the sync byte at any bit alignment. It then reads a length byte
// and delivers the payload bytes MSB first. It also flags start/end of frame
// and framing errors.
// Build option: define MANCH_DEFRAME_CHECKSUM_EN to expect a trailing XOR
// checksum byte after the payload. The checksum is verified in a CHECK state.
module manchester_deframer #(
  parameter logic [7:0] SYNC    = 8'hD5,
  parameter int         MAX_LEN = 64,
  parameter int         TMO_CYC = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d_decod,
  input  logic       bit_en,
  output logic [7:0] byte_out,
  output logic       byte_vld,
  output logic       sof,
  output logic       eof,
  output logic       frm_err,
  output logic       busy
);

  localparam int            TW       = $clog2(TMO_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

  typedef enum logic [1:0] {
    S_HUNT    = 2'd0,
    S_LEN     = 2'd1,
    S_PAYLOAD = 2'd2
`ifdef MANCH_DEFRAME_CHECKSUM_EN
    , S_CHECK = 2'd3
`endif
  } state_t;

  state_t          r_state, w_state_next;
  logic [7:0]      r_sr, w_sr_next;
  logic [2:0]      r_bitcnt, w_bitcnt_next;
  logic [7:0]      r_len, w_len_next;
  logic [7:0]      r_rem, w_rem_next;
  logic [TW-1:0]   r_tmo, w_tmo_next;
  logic [7:0]      r_byte_out, w_byte_out_next;
  logic            r_vld, w_vld_next;
  logic            r_sof, w_sof_next;
  logic            r_eof, w_eof_next;
  logic            r_err, w_err_next;
`ifdef MANCH_DEFRAME_CHECKSUM_EN
  logic [7:0]      r_xor, w_xor_next;
`endif

  logic [7:0]      w_sr_shift;
  logic            w_byte_done;

  // Candidate shift-register value; every comparison looks at the post-shift byte
  assign w_sr_shift  = {r_sr[6:0], d_decod};
  assign w_byte_done = bit_en && (r_bitcnt == 3'd7);

  // Next-state, datapath and output-pulse decode
  always_comb begin
    w_state_next    = r_state;
    w_sr_next       = bit_en ? w_sr_shift : r_sr;
    w_bitcnt_next   = r_bitcnt;
    w_len_next      = r_len;
    w_rem_next      = r_rem;
    w_tmo_next      = '0;
    w_byte_out_next = r_byte_out;
    w_vld_next      = 1'b0;
    w_sof_next      = 1'b0;
    w_eof_next      = 1'b0;
    w_err_next      = 1'b0;
`ifdef MANCH_DEFRAME_CHECKSUM_EN
    w_xor_next      = r_xor;
`endif

    case (r_state)
      S_HUNT: begin
        // Sliding compare on every bit gives alignment at any bit offset
        if (bit_en && (w_sr_shift == SYNC)) begin
          w_state_next  = S_LEN;
          w_bitcnt_next = 3'd0;
        end
      end

      default: begin
        // In-frame states share bit counting and the idle-line timeout
        if (bit_en) begin
          w_bitcnt_next = r_bitcnt + 3'd1;
        end else if (r_tmo == TMO_LAST) begin
          w_err_next    = 1'b1;
          w_state_next  = S_HUNT;
          w_sr_next     = 8'h00;
          w_bitcnt_next = 3'd0;
        end else begin
          w_tmo_next = r_tmo + TW'(1);
        end

        if (w_byte_done) begin
          case (r_state)
            S_LEN: begin
              w_len_next = w_sr_shift;
              if ((w_sr_shift == 8'h00) || (int'(w_sr_shift) > MAX_LEN)) begin
                w_err_next   = 1'b1;
                w_state_next = S_HUNT;
                w_sr_next    = 8'h00;
              end else begin
                w_state_next = S_PAYLOAD;
                w_rem_next   = w_sr_shift;
`ifdef MANCH_DEFRAME_CHECKSUM_EN
                w_xor_next   = 8'h00;
`endif
              end
            end

            S_PAYLOAD: begin
              w_byte_out_next = w_sr_shift;
              w_vld_next      = 1'b1;
              w_sof_next      = (r_rem == r_len);
              w_rem_next      = r_rem - 8'd1;
`ifdef MANCH_DEFRAME_CHECKSUM_EN
              w_xor_next      = r_xor ^ w_sr_shift;
              if (r_rem == 8'd1) begin
                w_state_next = S_CHECK;
              end
`else
              if (r_rem == 8'd1) begin
                w_eof_next   = 1'b1;
                w_state_next = S_HUNT;
                w_sr_next    = 8'h00;
              end
`endif
            end

`ifdef MANCH_DEFRAME_CHECKSUM_EN
            S_CHECK: begin
              w_eof_next   = 1'b1;
              w_err_next   = (w_sr_shift != r_xor);
              w_state_next = S_HUNT;
              w_sr_next    = 8'h00;
            end
`endif

            default: ;
          endcase
        end
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_HUNT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath and registered output pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr       <= 8'h00;
      r_bitcnt   <= 3'd0;
      r_len      <= 8'h00;
      r_rem      <= 8'h00;
      r_tmo      <= '0;
      r_byte_out <= 8'h00;
      r_vld      <= 1'b0;
      r_sof      <= 1'b0;
      r_eof      <= 1'b0;
      r_err      <= 1'b0;
`ifdef MANCH_DEFRAME_CHECKSUM_EN
      r_xor      <= 8'h00;
`endif
    end else begin
      r_sr       <= w_sr_next;
      r_bitcnt   <= w_bitcnt_next;
      r_len      <= w_len_next;
      r_rem      <= w_rem_next;
      r_tmo      <= w_tmo_next;
      r_byte_out <= w_byte_out_next;
      r_vld      <= w_vld_next;
      r_sof      <= w_sof_next;
      r_eof      <= w_eof_next;
      r_err      <= w_err_next;
`ifdef MANCH_DEFRAME_CHECKSUM_EN
      r_xor      <= w_xor_next;
`endif
    end
  end

  // Pulses are masked while reset is held so none can escape during rst
  assign byte_out = r_byte_out;
  assign byte_vld = r_vld & ~rst;
  assign sof      = r_sof & ~rst;
  assign eof      = r_eof & ~rst;
  assign frm_err  = r_err & ~rst;
  assign busy     = (r_state != S_HUNT);

endmodule
